checkpoint_table: RTL and testbench
===================================

// Module: checkpoint_table
// PURPOSE
//  Stores rename-map snapshots (checkpointed_rmt) at branches and returns a snapshot as
//  recalled_rmt + if_recall on a mispredict; it is the other end of the rename map's
//  checkpoint/recall interface. Circular buffer, entries allocated and freed in program order.
//  Sits beside the rename map; the branch unit drives resolve_*, decode reads full.
// PARAMETERS
//  NUM_CP   4                 checkpoint entries; power of 2, >=2
//  PR_W     $clog2(`NUM_PR)   physical register tag width
// PORTS
//  clk              in   1              clock
//  reset            in   1              async reset, active-low
//  ext_stall        in   1              rename stalled; allocation suppressed
//  alloc_valid      in   1              branch renamed this cycle; capture snapshot
//  checkpointed_rmt in   PR_W x32       snapshot from rename map
//  alloc_ack        out  1              comb: snapshot taken this cycle
//  alloc_id         out  $clog2(NUM_CP) comb: tag assigned (current tail)
//  full             out  1              registered: count==NUM_CP
//  resolve_valid    in   1              branch resolved
//  resolve_id       in   $clog2(NUM_CP) tag of resolved branch
//  resolve_mispred  in   1              1 = mispredict, restore that entry
//  if_recall        out  1              registered: 1-cycle restore pulse to rename map
//  recalled_rmt     out  PR_W x32       registered snapshot, valid while if_recall=1
//  count            out  $clog2(NUM_CP)+1 live entries
// BEHAVIOUR
//  - Reset (async, reset=0): head=tail=0, all valid/done bits=0, count=0, full=0,
//    if_recall=0, recalled_rmt[i]=i. Reset mid-recall aborts the pulse immediately.
//  - Per entry: snapshot[32], valid, done. head=oldest, tail=next free; ptrs wrap mod NUM_CP.
//  - alloc_ack = alloc_valid & ~full & ~ext_stall & ~if_recall & ~(resolve_valid&resolve_mispred).
//    On ack: entry[tail] <= snapshot, valid=1, done=0; tail++, count++.
//  - alloc_valid while full: no ack, no state change; upstream holds the branch.
//  - Correct resolve (mispred=0): entry[id].done<=1. Each cycle, if entry[head] valid&done,
//    clear it, head++, count-- (at most one retire per cycle).
//  - Mispredict at id k: next cycle if_recall=1, recalled_rmt=entry[k].snapshot; entry k
//    and all younger (k..tail-1, wrapping) cleared; tail<=k; count<=entries from head to k-1.
//    if_recall deasserts the following cycle unless another mispredict arrives.
//  - Simultaneous mispredict + alloc: mispredict wins, alloc not acked.
//  - Simultaneous head retire + mispredict at id k!=head: both apply; count consistent.
//  - Mispredict at k==head: table becomes empty (head==tail==k, count=0).
//  - Resolve to an invalid entry: ignored (assert in sim).
//  - Empty vs full with head==tail disambiguated by count.
// CONFIGURATION
//  CP_PERF_CNT_EN defined: adds outputs perf_full_cycles[31:0] (cycles with alloc_valid &
//   full) and perf_recalls[31:0] (if_recall pulses); both saturate, reset to 0.
//  Undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
//  1 Reset, alloc x1 with rmt[i]=i+32 -> alloc_id=0, ack=1, count=1, full=0.
//  2 Alloc 4 (ids 0..3) -> full=1; 5th alloc_valid -> ack=0, tail unchanged.
//  3 Resolve id1 correct, then id0 correct -> head 0->2 over 2 cycles, count 4->2.
//  4 Ids 0..2 live, mispredict id1 -> next cycle if_recall=1, recalled_rmt=snapshot1,
//    count=1, tail=1; next alloc gets alloc_id=1.
//  5 Mispredict id0 same cycle as alloc_valid -> ack=0, count=0, if_recall next cycle.
//  6 Wrap: head=3 with 2 live (3,0); mispredict id0 -> count=1, tail=0; reset
//    during if_recall -> if_recall=0 immediately.

Source files
------------

// File: rtl/checkpoint_table.sv
// checkpoint_table: circular buffer of rename-map snapshots taken at branches, replayed on mispredict.
// Define CP_PERF_CNT_EN to add saturating perf counters (full-stall cycles, recall pulses).
`ifndef NUM_PR
`define NUM_PR 64
`endif

module cp_entry #(
  parameter int PR_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  set_done,
  input  logic                  clr,
  input  logic [31:0][PR_W-1:0] snap_in,
  output logic [31:0][PR_W-1:0] snap,
  output logic                  valid,
  output logic                  done
);
  // Flush/retire beats a same-cycle done mark; alloc never targets a live entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      done  <= 1'b0;
    end else if (set_done) begin
      done  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) snap <= snap_in;
  end
endmodule

module checkpoint_table #(
  parameter int NUM_CP = 4,
  parameter int PR_W   = $clog2(`NUM_PR)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ext_stall,
  input  logic                        alloc_valid,
  input  logic [31:0][PR_W-1:0]       checkpointed_rmt,
  output logic                        alloc_ack,
  output logic [$clog2(NUM_CP)-1:0]   alloc_id,
  output logic                        full,
  input  logic                        resolve_valid,
  input  logic [$clog2(NUM_CP)-1:0]   resolve_id,
  input  logic                        resolve_mispred,
  output logic                        if_recall,
  output logic [31:0][PR_W-1:0]       recalled_rmt,
  output logic [$clog2(NUM_CP):0]     count
`ifdef CP_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_full_cycles,
  output logic [31:0]                 perf_recalls
`endif
);
  localparam int ID_W  = $clog2(NUM_CP);
  localparam int CNT_W = ID_W + 1;

  logic [ID_W-1:0]  head, tail, head_n, tail_n, k_off;
  logic [CNT_W-1:0] count_n;
  logic             mispred_go, done_go, retire;

  logic [NUM_CP-1:0]                  ent_valid, ent_done, ent_wr, ent_set, ent_clr;
  logic [NUM_CP-1:0][31:0][PR_W-1:0]  ent_snap;

  // Resolves aimed at dead entries are dropped entirely.
  assign mispred_go = resolve_valid & resolve_mispred & ent_valid[resolve_id];
  assign done_go    = resolve_valid & ~resolve_mispred & ent_valid[resolve_id];
  assign k_off      = resolve_id - head;
  assign retire     = ent_valid[head] & ent_done[head] & ~(mispred_go & (resolve_id == head));

  assign alloc_ack  = alloc_valid & ~full & ~ext_stall & ~if_recall & ~(resolve_valid & resolve_mispred);
  assign alloc_id   = tail;

  // Age offset from head decides which entries a mispredict squashes (k and younger).
  for (genvar g = 0; g < NUM_CP; g++) begin : g_ent
    logic [ID_W-1:0] off;
    assign off        = ID_W'(g) - head;
    assign ent_wr[g]  = alloc_ack && (tail == ID_W'(g));
    assign ent_set[g] = done_go && (resolve_id == ID_W'(g));
    assign ent_clr[g] = (retire && (head == ID_W'(g))) || (mispred_go && (off >= k_off));

    cp_entry #(.PR_W(PR_W)) u_ent (
      .clk      (clk),
      .reset    (reset),
      .wr       (ent_wr[g]),
      .set_done (ent_set[g]),
      .clr      (ent_clr[g]),
      .snap_in  (checkpointed_rmt),
      .snap     (ent_snap[g]),
      .valid    (ent_valid[g]),
      .done     (ent_done[g])
    );
  end

  always_comb begin
    head_n  = head + ID_W'(retire);
    tail_n  = tail + ID_W'(alloc_ack);
    count_n = count + CNT_W'(alloc_ack) - CNT_W'(retire);
    if (mispred_go) begin
      tail_n  = resolve_id;
      count_n = {1'b0, k_off} - CNT_W'(retire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      full      <= 1'b0;
      if_recall <= 1'b0;
      for (int i = 0; i < 32; i++) recalled_rmt[i] <= PR_W'(i);
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      full      <= (count_n == CNT_W'(NUM_CP));
      if_recall <= mispred_go;
      if (mispred_go) recalled_rmt <= ent_snap[resolve_id];
    end
  end

`ifdef CP_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_full_cycles <= '0;
      perf_recalls     <= '0;
    end else begin
      if (alloc_valid && full && (perf_full_cycles != '1)) perf_full_cycles <= perf_full_cycles + 32'd1;
      if (if_recall && (perf_recalls != '1))               perf_recalls     <= perf_recalls + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_resolve_live: assert property (@(posedge clk) disable iff (!reset)
    resolve_valid |-> ent_valid[resolve_id]);
`endif
endmodule

// File: tb/tb_checkpoint_table.sv
// Scoreboard bench for checkpoint_table: stimulus queues expectations, one negedge monitor compares.
module tb_checkpoint_table;
  typedef logic [31:0][5:0] rmt_t;
  typedef struct { logic [2:0] cnt; logic full; logic [1:0] id; logic ack; logic rec; logic chk_rmt; rmt_t rmt; } st_t;
  typedef struct { rmt_t rmt; logic [2:0] cnt; logic [1:0] tail; } rec_t;

  logic       clk = 1'b0;
  logic       reset, ext_stall, alloc_valid, alloc_ack, full;
  logic       resolve_valid, resolve_mispred, if_recall;
  logic [1:0] alloc_id, resolve_id;
  logic [2:0] count;
  rmt_t       checkpointed_rmt, recalled_rmt;

  checkpoint_table #(.NUM_CP(4), .PR_W(6)) dut (
    .clk              (clk),
    .reset            (reset),
    .ext_stall        (ext_stall),
    .alloc_valid      (alloc_valid),
    .checkpointed_rmt (checkpointed_rmt),
    .alloc_ack        (alloc_ack),
    .alloc_id         (alloc_id),
    .full             (full),
    .resolve_valid    (resolve_valid),
    .resolve_id       (resolve_id),
    .resolve_mispred  (resolve_mispred),
    .if_recall        (if_recall),
    .recalled_rmt     (recalled_rmt),
    .count            (count)
  );

  always #5 clk = ~clk;

  logic [1:0] ack_q[$];
  rec_t       rec_q[$];
  st_t        st_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic       fin_req = 1'b0;
  logic       fin_ack = 1'b0;
  rec_t       mon_r;
  st_t        mon_s;

  function automatic rmt_t pat(input int base);
    rmt_t r;
    for (int i = 0; i < 32; i++) r[i] = 6'((i + base) % 64);
    return r;
  endfunction

  function automatic void cmp(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor: sole owner of the comparison counters.
  always @(negedge clk) begin
    if (reset) begin
      if (alloc_ack) begin
        if (ack_q.size() == 0) cmp("ack_unexpected", 192'(alloc_ack), 192'(0));
        else cmp("ack_id", 192'(alloc_id), 192'(ack_q.pop_front()));
      end
      if (if_recall) begin
        if (rec_q.size() == 0) cmp("recall_unexpected", 192'(if_recall), 192'(0));
        else begin
          mon_r = rec_q.pop_front();
          cmp("recall_rmt", recalled_rmt, mon_r.rmt);
          cmp("recall_count", 192'(count), 192'(mon_r.cnt));
          cmp("recall_tail", 192'(alloc_id), 192'(mon_r.tail));
        end
      end
    end
    while (st_q.size() > 0) begin
      mon_s = st_q.pop_front();
      cmp("count", 192'(count), 192'(mon_s.cnt));
      cmp("full", 192'(full), 192'(mon_s.full));
      cmp("alloc_id", 192'(alloc_id), 192'(mon_s.id));
      cmp("alloc_ack", 192'(alloc_ack), 192'(mon_s.ack));
      cmp("if_recall", 192'(if_recall), 192'(mon_s.rec));
      if (mon_s.chk_rmt) cmp("reset_rmt", recalled_rmt, mon_s.rmt);
    end
    if (fin_req && !fin_ack) begin
      cmp("ack_left", 192'(ack_q.size()), 192'(0));
      cmp("recall_left", 192'(rec_q.size()), 192'(0));
      fin_ack = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; ext_stall = 1'b0;
    resolve_valid = 1'b0; resolve_mispred = 1'b0; resolve_id = 2'd0;
  endtask

  task automatic exp_st(input int c, input logic f, input int id, input logic a, input logic rc);
    st_t s;
    s.cnt = 3'(c); s.full = f; s.id = 2'(id); s.ack = a; s.rec = rc; s.chk_rmt = 1'b0; s.rmt = '0;
    st_q.push_back(s);
  endtask

  task automatic exp_reset_state();
    st_t s;
    s.cnt = 3'd0; s.full = 1'b0; s.id = 2'd0; s.ack = 1'b0; s.rec = 1'b0; s.chk_rmt = 1'b1; s.rmt = pat(0);
    st_q.push_back(s);
  endtask

  task automatic exp_rec(input rmt_t r, input int c, input int t);
    rec_t e;
    e.rmt = r; e.cnt = 3'(c); e.tail = 2'(t);
    rec_q.push_back(e);
  endtask

  task automatic alloc(input int base, input int id, input int c);
    idle(); alloc_valid = 1'b1; checkpointed_rmt = pat(base);
    ack_q.push_back(2'(id));
    exp_st(c, 1'b0, id, 1'b1, 1'b0);
    step();
  endtask

  task automatic resolve(input int id, input logic mp);
    idle(); resolve_valid = 1'b1; resolve_mispred = mp; resolve_id = 2'(id);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    idle(); checkpointed_rmt = '0; reset = 1'b0;
    #1 exp_reset_state();
    step(); step();
    reset = 1'b1;

    // 1/2: fill ids 0..3, then held alloc while full gets no ack and tail stays
    alloc(32, 0, 0); alloc(40, 1, 1); alloc(48, 2, 2); alloc(56, 3, 3);
    alloc_valid = 1'b1; checkpointed_rmt = pat(99);
    exp_st(4, 1'b1, 0, 1'b0, 1'b0); step();
    exp_st(4, 1'b1, 0, 1'b0, 1'b0); step();

    // 3: resolve 1 then 0 correct; head retires 0 then 1
    resolve(1, 1'b0); exp_st(4, 1'b1, 0, 1'b0, 1'b0); step();
    resolve(0, 1'b0); exp_st(4, 1'b1, 0, 1'b0, 1'b0); step();
    idle();           exp_st(4, 1'b1, 0, 1'b0, 1'b0); step();
    exp_st(3, 1'b0, 0, 1'b0, 1'b0); step();
    exp_st(2, 1'b0, 0, 1'b0, 1'b0); step();

    // head 2 retires in the same cycle as a mispredict at 3
    resolve(2, 1'b0); exp_st(2, 1'b0, 0, 1'b0, 1'b0); step();
    resolve(3, 1'b1); exp_rec(pat(56), 0, 3); exp_st(2, 1'b0, 0, 1'b0, 1'b0); step();
    idle(); exp_st(0, 1'b0, 3, 1'b0, 1'b1); step();
    exp_st(0, 1'b0, 3, 1'b0, 1'b0); step();

    // 4: ids 0..2 live, mispredict 1; alloc blocked during recall, then gets id 1
    reset = 1'b0; step(); reset = 1'b1;
    alloc(1, 0, 0); alloc(2, 1, 1); alloc(3, 2, 2);
    resolve(1, 1'b1); exp_rec(pat(2), 1, 1); exp_st(3, 1'b0, 3, 1'b0, 1'b0); step();
    idle(); alloc_valid = 1'b1; checkpointed_rmt = pat(7);
    exp_st(1, 1'b0, 1, 1'b0, 1'b1); step();
    alloc(7, 1, 1);

    // 5: mispredict at head 0 with alloc_valid in the same cycle
    resolve(0, 1'b1); alloc_valid = 1'b1; checkpointed_rmt = pat(9);
    exp_rec(pat(1), 0, 0); exp_st(2, 1'b0, 2, 1'b0, 1'b0); step();
    idle(); exp_st(0, 1'b0, 0, 1'b0, 1'b1); step();

    // 6: wrap to head 3 with live 3,0; mispredict 0, then head 3, reset mid-pulse
    alloc(10, 0, 0); alloc(11, 1, 1); alloc(12, 2, 2); alloc(13, 3, 3);
    resolve(0, 1'b0); exp_st(4, 1'b1, 0, 1'b0, 1'b0); step();
    resolve(1, 1'b0); exp_st(4, 1'b1, 0, 1'b0, 1'b0); step();
    resolve(2, 1'b0); exp_st(3, 1'b0, 0, 1'b0, 1'b0); step();
    idle(); exp_st(2, 1'b0, 0, 1'b0, 1'b0); step();
    exp_st(1, 1'b0, 0, 1'b0, 1'b0); step();
    alloc(20, 0, 1);
    resolve(0, 1'b1); exp_rec(pat(20), 1, 0); exp_st(2, 1'b0, 1, 1'b0, 1'b0); step();
    resolve(3, 1'b1); exp_st(1, 1'b0, 0, 1'b0, 1'b1); step();
    idle(); #2 reset = 1'b0;
    exp_reset_state();
    step(); reset = 1'b1; step();

    fin_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
